// File: rtl/bsg_link_pkg.sv
// rtl/bsg_link_pkg.sv - shared types and constants for the off-chip byte link
// Used by both the upstream transmitter and the downstream receiver.
package bsg_link_pkg;

    localparam int LINK_CREDIT_W = 7;

    typedef logic [7:0]  link_byte_t;
    typedef logic [15:0] link_half_t;
    typedef logic [31:0] core_word_t;

    // Transmit serialiser: two bytes of the low half, then two of the high half.
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_LO_B0 = 3'd1,
        TX_LO_B1 = 3'd2,
        TX_HI_B0 = 3'd3,
        TX_HI_B1 = 3'd4
    } tx_state_e;

endpackage

// File: rtl/bsg_upstream_tx_fifo.sv
// rtl/bsg_upstream_tx_fifo.sv - core-side word FIFO of the upstream transmitter
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, push_data write request and word (ignored while full)
//   pop, pop_data   read request and combinational head word (ignored while empty)
//   full, empty     status, decoded from registered pointers
module bsg_upstream_tx_fifo
    import bsg_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  core_word_t push_data,
    input  logic       pop,
    output core_word_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    core_word_t    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = (wptr == rptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bsg_upstream_tx.sv
// rtl/bsg_upstream_tx.sv - credit-based 32-bit to 8-bit upstream link transmitter
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   core_data_in/valid/ready_out   core word stream, [15:0] sent first, low byte first
//   io_data_out, io_valid_out      registered link byte stream
//   io_token_in                    one-cycle pulse returning one 16-bit credit
//   credit_cnt                     current credit count
//   credit_err                     sticky credit-overflow flag (only with
//                                  BSG_UPSTREAM_TX_CREDIT_CHECK_EN defined)
module bsg_upstream_tx
    import bsg_link_pkg::*;
#(
    parameter int CREDITS    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  core_word_t               core_data_in,
    input  logic                     core_valid_in,
    output logic                     core_ready_out,
    output link_byte_t               io_data_out,
    output logic                     io_valid_out,
    input  logic                     io_token_in,
    output logic [LINK_CREDIT_W-1:0] credit_cnt
`ifdef BSG_UPSTREAM_TX_CREDIT_CHECK_EN
    ,
    output logic                     credit_err
`endif
);

    localparam logic [LINK_CREDIT_W-1:0] CREDIT_MAX = LINK_CREDIT_W'(CREDITS);

    tx_state_e  state;
    tx_state_e  state_n;
    logic       lo_wait;
    logic       lo_wait_n;
    core_word_t word_q;
    core_word_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       consume;
    logic       credit_ok;
    logic       emit_valid;
    link_byte_t emit_byte;

    bsg_upstream_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (core_valid_in),
        .push_data(core_data_in),
        .pop      (pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign core_ready_out = !fifo_full;

    // Decisions use the registered count, so a token arriving while the
    // count is zero only enables a half on the following cycle.
    assign credit_ok = (credit_cnt != '0);

    always_comb begin
        state_n    = state;
        lo_wait_n  = lo_wait;
        pop        = 1'b0;
        consume    = 1'b0;
        emit_valid = 1'b0;
        emit_byte  = '0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty && credit_ok) begin
                    state_n = TX_LO_B0;
                    pop     = 1'b1;
                    consume = 1'b1;
                end
            end
            TX_LO_B0: begin
                emit_valid = 1'b1;
                emit_byte  = word_q[7:0];
                state_n    = TX_LO_B1;
            end
            TX_LO_B1: begin
                // The high byte of the low half goes out on the first cycle
                // only; further cycles here are the inter-half credit stall.
                emit_valid = !lo_wait;
                emit_byte  = word_q[15:8];
                if (credit_ok) begin
                    state_n   = TX_HI_B0;
                    consume   = 1'b1;
                    lo_wait_n = 1'b0;
                end else begin
                    lo_wait_n = 1'b1;
                end
            end
            TX_HI_B0: begin
                emit_valid = 1'b1;
                emit_byte  = word_q[23:16];
                state_n    = TX_HI_B1;
            end
            TX_HI_B1: begin
                emit_valid = 1'b1;
                emit_byte  = word_q[31:24];
                if (!fifo_empty && credit_ok) begin
                    state_n = TX_LO_B0;
                    pop     = 1'b1;
                    consume = 1'b1;
                end else begin
                    state_n = TX_IDLE;
                end
            end
            default: begin
                state_n = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= TX_IDLE;
            lo_wait <= 1'b0;
            word_q  <= '0;
        end else begin
            state   <= state_n;
            lo_wait <= lo_wait_n;
            if (pop) begin
                word_q <= fifo_head;
            end
        end
    end

    // Link outputs trail the state register by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            io_valid_out <= 1'b0;
            io_data_out  <= '0;
        end else begin
            io_valid_out <= emit_valid;
            io_data_out  <= emit_byte;
        end
    end

    // Overflow tokens saturate at CREDITS; token plus consume cancels out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_cnt <= CREDIT_MAX;
        end else if (io_token_in && !consume) begin
            if (credit_cnt != CREDIT_MAX) begin
                credit_cnt <= credit_cnt + LINK_CREDIT_W'(1);
            end
        end else if (consume && !io_token_in) begin
            credit_cnt <= credit_cnt - LINK_CREDIT_W'(1);
        end
    end

`ifdef BSG_UPSTREAM_TX_CREDIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_err <= 1'b0;
        end else if (io_token_in && (credit_cnt == CREDIT_MAX)) begin
            credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_upstream_tx.sv
// tb/tb_bsg_upstream_tx.sv - scoreboard testbench for bsg_upstream_tx
module tb_bsg_upstream_tx;

    localparam int CREDITS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] core_data_in = '0;
    logic        core_valid_in = 1'b0;
    logic        core_ready_out;
    logic [7:0]  io_data_out;
    logic        io_valid_out;
    logic        io_token_in = 1'b0;
    logic [6:0]  credit_cnt;
`ifdef BSG_UPSTREAM_TX_CREDIT_CHECK_EN
    logic        credit_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    int  owed     = 0;
    int  byte_idx = 0;
    int  m_last   = CREDITS;
    int  tok_last = 0;
    int  a_last   = CREDITS;
    int  cons;
    int  m_now;
    bit  mon_en   = 1'b0;
    logic s_rst = 1'b0;
    logic s_tok = 1'b0;

    bsg_upstream_tx #(
        .CREDITS(CREDITS),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_data_in  (core_data_in),
        .core_valid_in (core_valid_in),
        .core_ready_out(core_ready_out),
        .io_data_out   (io_data_out),
        .io_valid_out  (io_valid_out),
        .io_token_in   (io_token_in),
        .credit_cnt    (credit_cnt)
`ifdef BSG_UPSTREAM_TX_CREDIT_CHECK_EN
        ,
        .credit_err    (credit_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted words become four expected bytes, low byte first.
    always @(posedge clk) begin
        s_rst <= rst;
        s_tok <= io_token_in;
        if (rst && core_valid_in && core_ready_out) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(core_data_in[8*i +: 8]);
        end
    end

    // Monitor: byte scoreboard, pairing rule and a one-cycle-late credit model.
    // A half's first byte at edge n means its credit was taken at edge n-1.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!s_rst) begin
                exp_q.delete();
                byte_idx = 0;
                owed     = 0;
                m_last   = CREDITS;
                tok_last = 0;
                a_last   = int'(credit_cnt);
                check("rst_valid", io_valid_out, 0);
                check("rst_data", io_data_out, 0);
                check("rst_credit", credit_cnt, CREDITS);
            end else begin
                cons = (io_valid_out && (byte_idx == 0 || byte_idx == 2)) ? 1 : 0;
                if (byte_idx == 1 || byte_idx == 3) check("pair_gap", io_valid_out, 1);
                m_now = m_last + tok_last - cons;
                if (m_now > CREDITS) m_now = CREDITS;
                check("credit", a_last, m_now);
                m_last   = m_now;
                tok_last = int'(s_tok);
                a_last   = int'(credit_cnt);
                owed     = owed + cons;
                if (io_valid_out) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got %0h expected none", io_data_out);
                    end else begin
                        check("byte", io_data_out, exp_q.pop_front());
                    end
                    byte_idx = (byte_idx + 1) % 4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic give_token();
        io_token_in = 1'b1;
        owed--;
        tick();
        io_token_in = 1'b0;
    endtask

    task automatic restore_tokens();
        int b = 0;
        while (owed > 0 && b < 500) begin
            give_token();
            b++;
        end
        tick();
        tick();
    endtask

    // Holds valid until n words are accepted; returns the cycles used.
    task automatic push_burst(input int n, input int bound, output int cycles);
        int  cnt = 0;
        bit  acc;
        cycles = 0;
        core_valid_in = 1'b1;
        core_data_in  = $urandom;
        while (cnt < n && cycles < bound) begin
            acc = core_ready_out;
            tick();
            cycles++;
            if (acc) begin
                cnt++;
                core_data_in = $urandom;
            end
        end
        core_valid_in = 1'b0;
        check("push_done", cnt, n);
    endtask

    task automatic wait_q(input int target, input int bound, input string name);
        int c = 0;
        while (exp_q.size() > target && c < bound) begin
            tick();
            c++;
        end
        check(name, exp_q.size() <= target, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat;
        int  run;
        int  cyc;
        int  c;
        bit  acc;
        bit  quiet;

        // Reset
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_ready", core_ready_out, 1);

        // Single word: byte order, latency, two credits consumed
        core_data_in  = 32'hDDCCBBAA;
        core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        lat = 0;
        while (!io_valid_out && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 2);
        wait_q(0, 20, "single_drain");
        tick();
        check("credit_after_word", credit_cnt, CREDITS - 2);

        // Three back-to-back words: accepted in 3 cycles, 12 bytes with no bubble
        push_burst(3, 20, cyc);
        check("b2b_accept_cycles", cyc, 3);
        c = 0;
        while (!io_valid_out && c < 10) begin
            tick();
            c++;
        end
        run = 0;
        while (io_valid_out && run < 20) begin
            run++;
            tick();
        end
        check("b2b_run", run, 12);
        restore_tokens();
        check("credit_restored", credit_cnt, CREDITS);

        // Overflow token at full credit saturates
        io_token_in = 1'b1;
        tick();
        io_token_in = 1'b0;
        tick();
        check("overflow_sat", credit_cnt, CREDITS);
`ifdef BSG_UPSTREAM_TX_CREDIT_CHECK_EN
        check("credit_err", credit_err, 1);
`endif

        // Drain all credits, then fill the FIFO with none available
        push_burst(32, 400, cyc);
        wait_q(0, 400, "drain_all");
        tick();
        check("credit_zero", credit_cnt, 0);
        push_burst(4, 20, cyc);
        tick();
        check("fifo_full", core_ready_out, 0);
        give_token();
        tick();
        check("ready_after_pop", core_ready_out, 1);
        wait_q(14, 20, "low_half_sent");
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (io_valid_out) quiet = 1'b0;
            tick();
        end
        check("stall_quiet", quiet, 1);
        give_token();
        wait_q(12, 6, "resume_high_half");
        for (int i = 0; i < 6; i++) begin
            give_token();
            repeat (3) tick();
        end
        wait_q(0, 100, "full_fifo_drain");
        restore_tokens();
        check("credit_restored2", credit_cnt, CREDITS);

        // Randomised traffic with randomly returned tokens
        core_data_in = $urandom;
        for (int i = 0; i < 600; i++) begin
            core_valid_in = ($urandom % 3) != 0;
            io_token_in   = (owed > 0) && ($urandom % 2 == 1);
            if (io_token_in) owed--;
            acc = core_valid_in && core_ready_out;
            tick();
            if (acc) core_data_in = $urandom;
        end
        core_valid_in = 1'b0;
        io_token_in   = 1'b0;
        c = 0;
        while ((exp_q.size() > 0 || owed > 0) && c < 3000) begin
            io_token_in = (owed > 0);
            if (io_token_in) owed--;
            tick();
            c++;
        end
        io_token_in = 1'b0;
        check("random_drain", exp_q.size(), 0);
        tick();
        tick();
        check("credit_restored3", credit_cnt, CREDITS);

        // Reset while the HI_B0 byte is on the link
        core_data_in  = 32'h87654321;
        core_valid_in = 1'b1;
        tick();
        core_valid_in = 1'b0;
        c = 0;
        while (exp_q.size() != 1 && c < 20) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("reached_hi_b0", io_data_out, 8'h65);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_valid", io_valid_out, 0);
        check("midrst_credit", credit_cnt, CREDITS);
        check("midrst_ready", core_ready_out, 1);
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (io_valid_out) quiet = 1'b0;
            tick();
        end
        check("midrst_no_bytes", quiet, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
